key_event_fifo: RTL and testbench

//  Memory-mapped key/switch input peripheral for the DB processor bus. Debounces a

---
 rtl/key_event_fifo.sv | 154 +++++++++++++++
 tb/tb_key_event_fifo.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/key_event_fifo.sv
// Debounced active-low key bank feeding an event FIFO with DATA/CTRL bus registers and level IRQ.
// Define KEY_DEBOUNCE_EN to require DB_CYCLES of stability before a change is accepted.
module key_event_fifo #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DB_CYCLES = 16,
  parameter logic [31:0] KDATA     = 32'hF000_0010,
  parameter logic [31:0] KCTRL     = 32'hF000_0110
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [31:0]      abus,
  input  logic [31:0]      dbus,
  input  logic             wren,
  input  logic [WIDTH-1:0] value,
  output logic [31:0]      dbusout,
  output logic             intr
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [WIDTH-1:0] stable_q, stable_d;
  logic             push;
  logic [WIDTH-1:0] evt_word;

  assign evt_word = ~value;

`ifdef KEY_DEBOUNCE_EN
  localparam int unsigned DbW = $clog2(DB_CYCLES + 1);

  logic [WIDTH-1:0] prev_q;
  logic [DbW-1:0]   db_cnt_q, db_cnt_d;

  // Counter only advances while raw is steady and differs from the accepted value.
  always_comb begin
    stable_d = stable_q;
    db_cnt_d = '0;
    push     = 1'b0;
    if (value == prev_q && value != stable_q) begin
      if (db_cnt_q == DbW'(DB_CYCLES - 1)) begin
        stable_d = value;
        push     = 1'b1;
      end else begin
        db_cnt_d = db_cnt_q + DbW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      prev_q   <= value;
      stable_q <= value;
      db_cnt_q <= '0;
    end else begin
      prev_q   <= value;
      stable_q <= stable_d;
      db_cnt_q <= db_cnt_d;
    end
  end
`else
  localparam int unsigned unused_db_cycles = DB_CYCLES;

  always_comb begin
    stable_d = value;
    push     = (value != stable_q);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stable_q <= value;
    end else begin
      stable_q <= stable_d;
    end
  end
`endif

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic             overrun_q, overrun_d;
  logic             ie_q, ie_d;

  logic rd_data, rd_ctrl, wr_ctrl;
  logic empty, full, pop, accept;

  assign rd_data = !wren && (abus == KDATA);
  assign rd_ctrl = !wren && (abus == KCTRL);
  assign wr_ctrl = wren && (abus == KCTRL);

  assign empty  = (count_q == '0);
  assign full   = (count_q == CntW'(DEPTH));
  assign pop    = rd_data && !empty;
  // A pop in the same cycle frees the slot, so a full FIFO still accepts.
  assign accept = push && (!full || pop);

  always_comb begin
    rd_ptr_d  = rd_ptr_q;
    wr_ptr_d  = wr_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    ie_d      = ie_q;
    if (pop) rd_ptr_d = rd_ptr_q + PtrW'(1);
    if (accept) wr_ptr_d = wr_ptr_q + PtrW'(1);
    if (accept && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!accept && pop) begin
      count_d = count_q - CntW'(1);
    end
    if (wr_ctrl) begin
      ie_d = dbus[8];
      if (!dbus[2]) overrun_d = 1'b0;
    end
    if (push && !accept) overrun_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      ie_q      <= 1'b0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      ie_q      <= ie_d;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && accept) mem[wr_ptr_q] <= evt_word;
  end

  logic [3:0] count4;
  assign count4 = 4'(count_q);

  always_comb begin
    dbusout = '0;
    if (rd_data && !empty) begin
      dbusout = 32'(mem[rd_ptr_q]);
    end else if (rd_ctrl) begin
      dbusout = {12'b0, count4, 7'b0, ie_q, 5'b0, overrun_q, 1'b0, !empty};
    end
  end

  assign intr = ie_q && !empty;

  logic unused_dbus;
  assign unused_dbus = ^{dbus[31:9], dbus[7:3], dbus[1:0]};

endmodule

// File: tb/tb_key_event_fifo.sv
// Bench for key_event_fifo: queue-based model checked every cycle plus directed literal checks.
module tb_key_event_fifo;

  localparam int unsigned W  = 4;
  localparam int unsigned D  = 4;
  localparam int unsigned DB = 16;
  localparam logic [31:0] KDATA = 32'hF000_0010;
  localparam logic [31:0] KCTRL = 32'hF000_0110;
`ifdef KEY_DEBOUNCE_EN
  localparam int LAT = 17;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [31:0]   abus = '0;
  logic [31:0]   dbus = '0;
  logic          wren = 1'b0;
  logic [W-1:0]  value = 4'hF;
  logic [31:0]   dbusout;
  logic          intr;

  key_event_fifo #(
    .WIDTH(W), .DEPTH(D), .DB_CYCLES(DB), .KDATA(KDATA), .KCTRL(KCTRL)
  ) dut (
    .clk(clk), .reset_n(reset_n), .abus(abus), .dbus(dbus), .wren(wren),
    .value(value), .dbusout(dbusout), .intr(intr)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
  endfunction

  // Model: events queue, accepted value, and run length of the current raw value.
  logic [31:0]  q[$];
  logic         m_ov, m_ie, m_valid = 1'b0;
  logic [W-1:0] m_stable, m_prev, ev;
  int           run;

  initial begin
    forever begin
      @(posedge clk);
      if (!reset_n) begin
        q.delete();
        m_ov = 1'b0; m_ie = 1'b0;
        m_stable = value; m_prev = value; run = 1;
        m_valid = 1'b1;
      end else begin
        bit do_pop, do_push, ov_set;
        do_pop = !wren && abus == KDATA && q.size() > 0;
        if (value != m_prev) run = 1;
        else run++;
        m_prev = value;
`ifdef KEY_DEBOUNCE_EN
        do_push = (value != m_stable) && (run == DB + 1);
`else
        do_push = (value != m_stable);
`endif
        ov_set = 1'b0;
        if (do_pop) void'(q.pop_front());
        if (do_push) begin
          m_stable = value;
          ev = ~value;
          if (q.size() < D) q.push_back(32'(ev));
          else ov_set = 1'b1;
        end
        if (wren && abus == KCTRL) begin
          m_ie = dbus[8];
          if (!dbus[2]) m_ov = 1'b0;
        end
        if (ov_set) m_ov = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_valid) begin
        logic [31:0] exp, sz;
        exp = '0;
        sz = q.size();
        if (!wren && abus == KDATA) begin
          if (q.size() > 0) exp = q[0];
        end else if (!wren && abus == KCTRL) begin
          exp[19:16] = sz[3:0];
          exp[8] = m_ie;
          exp[2] = m_ov;
          exp[0] = (sz != 0);
        end
        check("cyc_dbusout", dbusout, exp);
        check("cyc_intr", 32'(intr), 32'(m_ie && sz != 0));
      end
    end
  end

  task automatic idle();
    abus = '0; dbus = '0; wren = 1'b0;
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic rd_ctrl_chk(string nm, logic [31:0] exp);
    abus = KCTRL; wren = 1'b0;
    #3 check(nm, dbusout, exp);
    step(1);
    idle();
  endtask

  task automatic rd_data_chk(string nm, logic [31:0] exp);
    abus = KDATA; wren = 1'b0;
    #3 check(nm, dbusout, exp);
    step(1);
    idle();
  endtask

  task automatic bus_wr(logic [31:0] a, logic [31:0] d);
    abus = a; dbus = d; wren = 1'b1;
    step(1);
    idle();
  endtask

  task automatic intr_chk(string nm, logic e);
    #3 check(nm, 32'(intr), 32'(e));
    step(1);
  endtask

  task automatic do_reset();
    idle();
    value = 4'hF;
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  task automatic press(logic [W-1:0] v);
    value = v;
    step(LAT + 2);
  endtask

  initial begin
    // T1 reset, CTRL addressed during reset
    value = 4'hF; reset_n = 1'b0; abus = KCTRL;
    step(2);
    #3 check("t1_ctrl", dbusout, 32'h0);
    check("t1_intr", 32'(intr), 32'h0);
    step(1);
    reset_n = 1'b1; idle();
    step(2);

    // T2 single press, latency pinned by the read just before and after the push edge
    value = 4'hE;
    step(LAT - 1);
    rd_ctrl_chk("t2_before", 32'h0000_0000);
    rd_ctrl_chk("t2_after", 32'h0001_0001);
    step(3);
    rd_data_chk("t2_data", 32'h0000_0001);
    rd_ctrl_chk("t2_empty", 32'h0000_0000);
    press(4'hF);
    rd_data_chk("t2_release", 32'h0000_0000);

    // T3 bounce on bit0
    for (int i = 0; i < 12; i++) begin
      value[0] = ~value[0];
      step(5);
    end
    step(20);
`ifdef KEY_DEBOUNCE_EN
    rd_ctrl_chk("t3_count", 32'h0000_0000);
`endif

    // T4 overrun, then overrun-set racing a CTRL clear
    do_reset();
    press(4'hE); press(4'hD); press(4'hB); press(4'h7); press(4'h3);
    rd_ctrl_chk("t4_ctrl", 32'h0004_0005);
    bus_wr(KCTRL, 32'h0);
    rd_ctrl_chk("t4_clr", 32'h0004_0001);
    value = 4'h1;
    step(LAT - 1);
    bus_wr(KCTRL, 32'h0);
    rd_ctrl_chk("t4_setwins", 32'h0004_0005);
    rd_data_chk("t4_d0", 32'h1);
    rd_data_chk("t4_d1", 32'h2);
    rd_data_chk("t4_d2", 32'h4);
    rd_data_chk("t4_d3", 32'h8);
    rd_data_chk("t4_d4", 32'h0);
    bus_wr(KCTRL, 32'h0);
    rd_ctrl_chk("t4_final", 32'h0000_0000);

    // T5 push coinciding with pop while full
    do_reset();
    press(4'hE); press(4'hD); press(4'hB); press(4'h7);
    value = 4'h3;
    step(LAT - 1);
    rd_data_chk("t5_head", 32'h1);
    rd_ctrl_chk("t5_ctrl", 32'h0004_0001);
    rd_data_chk("t5_d1", 32'h2);
    rd_data_chk("t5_d2", 32'h4);
    rd_data_chk("t5_d3", 32'h8);
    rd_data_chk("t5_d4", 32'hC);

    // T6 interrupt; DATA writes have no effect
    do_reset();
    bus_wr(KCTRL, 32'h100);
    intr_chk("t6_intr_empty", 1'b0);
    bus_wr(KDATA, 32'hFFFF_FFFF);
    rd_ctrl_chk("t6_ctrl_ie", 32'h0000_0100);
    press(4'hE);
    intr_chk("t6_intr_set", 1'b1);
    rd_data_chk("t6_data", 32'h1);
    intr_chk("t6_intr_clr", 1'b0);

    // Reset with queued events discards them
    press(4'hD);
    do_reset();
    rd_ctrl_chk("t7_discard", 32'h0000_0000);

    step(2);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
